// File: rtl/mux_32x8.sv
// Width-down serializer: accepts WORD_W-bit words on a valid/ready handshake and
// emits them as NBYTES BYTE_W-bit bytes, MSB byte first, one byte per clk_4f cycle.
module mux_32x8 #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in_32x8,
  input  logic              valid_in_32x8,
  output logic              ready_out_32x8,
  output logic [BYTE_W-1:0] data_out_32x8,
  output logic              valid_out_32x8
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Handshake: a word transfers on a rising clk_4f edge where valid_in_32x8 and
  // ready_out_32x8 are both high; the source holds the word until that edge.
  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] hold_word;
  logic              hold_full;
  logic              accept;
  logic              last_edge;

  assign ready_out_32x8 = ~hold_full;
  assign accept         = valid_in_32x8 & ready_out_32x8;
  assign last_edge      = (state == SEND) && (cnt == LAST_CNT);

  // shreg holds only the bytes still to be shown; the byte being shown lives in data_out.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      shreg          <= '0;
      hold_word      <= '0;
      hold_full      <= 1'b0;
      data_out_32x8  <= '0;
      valid_out_32x8 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg          <= {data_in_32x8[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            data_out_32x8  <= data_in_32x8[WORD_W-1 -: BYTE_W];
            valid_out_32x8 <= 1'b1;
            cnt            <= '0;
            state          <= SEND;
          end
        end
        SEND: begin
          if (last_edge) begin
            cnt <= '0;
            if (hold_full) begin
              shreg          <= {hold_word[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              data_out_32x8  <= hold_word[WORD_W-1 -: BYTE_W];
              hold_full      <= 1'b0;
            end else if (accept) begin
              // Bypass: the input word goes straight to the output, no idle cycle.
              shreg          <= {data_in_32x8[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              data_out_32x8  <= data_in_32x8[WORD_W-1 -: BYTE_W];
            end else begin
              data_out_32x8  <= '0;
              valid_out_32x8 <= 1'b0;
              state          <= IDLE;
            end
          end else begin
            cnt           <= cnt + CW'(1);
            data_out_32x8 <= shreg[WORD_W-1 -: BYTE_W];
            shreg         <= shreg << BYTE_W;
            if (accept) begin
              hold_word <= data_in_32x8;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          state          <= IDLE;
          data_out_32x8  <= '0;
          valid_out_32x8 <= 1'b0;
        end
      endcase
    end
  end

endmodule
